alu_ctrl_pipe: RTL

Registered, handshaked successor to the combinational ALU control decoder. It accepts one instruction's opcode/funct per transfer and decodes it into an ALU operation code of parametrised width. Multi-cycle ops (mult, div) hold the block busy for a configurable number of cycles. It sits between the decode stage and the execute stage of the pipelined MIPS core, provides stall backpressure, and flags undecodable instructions.

---
 rtl/alu_ctrl_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder: opcode/funct in, alu_op/illegal out.
// mult/div hold the block busy for a configurable latency before their result is presented.
module alu_ctrl_pipe #(
    parameter int OP_W     = 4,
    parameter int MULT_CYC = 4,
    parameter int DIV_CYC  = 8,
    parameter int CNT_W    = $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  alu_op,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] busy_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        dec_code;
    logic              dec_ill;
    logic              dec_multi;
    logic [CNT_W-1:0]  dec_cnt;
    logic              load;

    // Combinational decode; dec_cnt is the busy count loaded on acceptance (LAT-1).
    always_comb begin
        dec_code  = 4'b0000;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_cnt   = '0;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000: dec_code = 4'b0010;
                6'b100010: dec_code = 4'b0110;
                6'b100100: dec_code = 4'b0000;
                6'b100101: dec_code = 4'b0101;
                6'b100111: dec_code = 4'b1100;
                6'b101010: dec_code = 4'b0111;
                6'b000000: dec_code = 4'b0100;
                6'b001000: dec_code = 4'b1111;
                6'b011000: begin
                    dec_code  = 4'b1101;
                    dec_multi = 1'b1;
                    dec_cnt   = CNT_W'(MULT_CYC - 1);
                end
                6'b011010: begin
                    dec_code  = 4'b1110;
                    dec_multi = 1'b1;
                    dec_cnt   = CNT_W'(DIV_CYC - 1);
                end
                default:   dec_ill = 1'b1;
            endcase
        end else begin
            case (opcode)
                6'b100011: dec_code = 4'b1000;
                6'b101011: dec_code = 4'b1001;
                6'b001000: dec_code = 4'b0011;
                6'b001100: dec_code = 4'b0001;
                6'b000100: dec_code = 4'b1010;
                6'b000011: dec_code = 4'b1011;
                default:   dec_ill  = 1'b1;
            endcase
        end
    end

    // in_ready never looks at in_valid, so no combinational loop through the handshake.
    assign in_ready = !reset_n
                   || (state_q == S_EMPTY)
                   || ((state_q == S_FULL) && out_ready);
    assign load     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush) begin
            // Discarded op leaves no residue on the output register.
            state_d   = S_EMPTY;
            cnt_d     = '0;
            alu_op_d  = '0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY, S_FULL: begin
                    if ((state_q == S_FULL) && out_ready) begin
                        state_d = S_EMPTY;
                    end
                    if (load) begin
                        alu_op_d  = OP_W'(dec_code);
                        illegal_d = dec_ill;
                        state_d   = dec_multi ? S_BUSY : S_FULL;
                        cnt_d     = dec_multi ? dec_cnt : '0;
                    end
                end
                S_BUSY: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_EMPTY;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign busy      = (state_q == S_BUSY);
    assign busy_cnt  = cnt_q;
    assign alu_op    = alu_op_q;
    assign illegal   = illegal_q;

endmodule
